// File: rtl/store_unit_pkg.sv
// Shared core definitions for the store path: store-width encodings and the
// store FSM state type.
package store_unit_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE_LO = 2'd1,
    WRITE_HI = 2'd2,
    DONE     = 2'd3
  } store_state_t;

  function automatic logic is_store_width(input logic [2:0] funct3);
    return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_align.sv
// Byte-lane positioning for stores: builds the 8-lane byte mask and the
// 64-bit lane data spanning the addressed word and the one after it.
module store_align
  import store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  mask,
  output logic [63:0] lane_data,
  output logic        width_ok
);

  logic [7:0]  base_mask;
  logic [31:0] sized_data;

  always_comb begin
    base_mask = 8'h00;
    case (funct3)
      F3_SB:   base_mask = 8'h01;
      F3_SH:   base_mask = 8'h03;
      F3_SW:   base_mask = 8'h0F;
      default: base_mask = 8'h00;
    endcase
    // Unused source bytes are zeroed so disabled lanes carry no stale data.
    sized_data = data & {{8{base_mask[3]}}, {8{base_mask[2]}},
                         {8{base_mask[1]}}, {8{base_mask[0]}}};
    mask      = base_mask << off;
    lane_data = {32'h0, sized_data} << {off, 3'b000};
  end

  assign width_ok = is_store_width(funct3);

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store request, issues one or two aligned write
// beats to memory, then pulses done (with fault if the request was rejected).
module store_unit
  import store_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  output logic              done,
  output logic              fault,
  output store_state_t      state
);

  logic [7:0]        mask;
  logic [63:0]       lane_data;
  logic              width_ok;
  logic              reject;
  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W-1:0] hi_addr;
  logic [31:0]       hi_wdata;
  logic [3:0]        hi_be;

  store_align u_align (
    .funct3    (req_funct3),
    .off       (req_addr[1:0]),
    .data      (req_data),
    .mask      (mask),
    .lane_data (lane_data),
    .width_ok  (width_ok)
  );

  assign lo_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign reject  = !width_ok || (!ALLOW_MISALIGNED && (mask[7:4] != 4'b0000));

  // Handshakes: a request transfers on a rising edge where req_valid and
  // req_ready are both high; a write beat transfers on a rising edge where
  // mem_we and mem_ready are both high, and mem_* hold until then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      hi_addr   <= '0;
      hi_wdata  <= '0;
      hi_be     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (reject) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= WRITE_LO;
              mem_we    <= 1'b1;
              mem_addr  <= lo_addr;
              mem_be    <= mask[3:0];
              mem_wdata <= lane_data[31:0];
              // The second beat is captured now so the request inputs are
              // free to change after acceptance.
              hi_addr   <= lo_addr + ADDR_W'(4);
              hi_be     <= mask[7:4];
              hi_wdata  <= lane_data[63:32];
            end
          end
        end
        WRITE_LO: begin
          if (mem_ready) begin
            if (hi_be != 4'b0000) begin
              state     <= WRITE_HI;
              mem_addr  <= hi_addr;
              mem_be    <= hi_be;
              mem_wdata <= hi_wdata;
            end else begin
              state  <= DONE;
              mem_we <= 1'b0;
              mem_be <= '0;
              done   <= 1'b1;
            end
          end
        end
        WRITE_HI: begin
          if (mem_ready) begin
            state  <= DONE;
            mem_we <= 1'b0;
            mem_be <= '0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          fault     <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed and random stores against a scoreboard of
// expected write beats and completion faults.
`timescale 1ns/1ps
module tb_store_unit;
  import store_unit_pkg::*;

  localparam int ADDR_W = 32;
  localparam int BEAT_W = ADDR_W + 4 + 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid_a, req_valid_b;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              mem_ready;

  logic              req_ready_a, mem_we_a, done_a, fault_a;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [31:0]       mem_wdata_a;
  logic [3:0]        mem_be_a;
  store_state_t      state_a;

  logic              req_ready_b, mem_we_b, done_b, fault_b;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [31:0]       mem_wdata_b;
  logic [3:0]        mem_be_b;
  store_state_t      state_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BEAT_W-1:0] exp_q[$];
  logic              exp_fault_q[$];
  logic [BEAT_W-1:0] exp_beat;
  logic              exp_fault;

  // clock / reset
  always #5 clk = ~clk;

  store_unit #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(ADDR_W)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_be(mem_be_a),
    .mem_ready(mem_ready), .done(done_a), .fault(fault_a), .state(state_a)
  );

  store_unit #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(ADDR_W)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_be(mem_be_b),
    .mem_ready(mem_ready), .done(done_b), .fault(fault_b), .state(state_b)
  );

  // scoreboard: beats and completions of dut_a popped as they occur
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      n_checks++;
      if (fault_a === 1'b1 && done_a !== 1'b1) begin
        n_fail++;
        $display("FAIL fault_without_done fault=%b done=%b", fault_a, done_a);
      end
      if (mem_we_a === 1'b1 && mem_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected addr=%h be=%b wdata=%h", mem_addr_a, mem_be_a, mem_wdata_a);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({mem_addr_a, mem_be_a, mem_wdata_a} !== exp_beat) begin
            n_fail++;
            $display("FAIL beat got addr=%h be=%b wdata=%h exp addr=%h be=%b wdata=%h",
                     mem_addr_a, mem_be_a, mem_wdata_a,
                     exp_beat[BEAT_W-1 -: ADDR_W], exp_beat[35:32], exp_beat[31:0]);
          end
        end
      end
      if (done_a === 1'b1) begin
        n_checks++;
        if (exp_fault_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected fault=%b", fault_a);
        end else begin
          exp_fault = exp_fault_q.pop_front();
          if (fault_a !== exp_fault) begin
            n_fail++;
            $display("FAIL done_fault got=%b exp=%b", fault_a, exp_fault);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic issue_a(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_funct3 = f3; req_addr = a; req_data = d; req_valid_a = 1'b1;
    n_checks++;
    if (req_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready_a got=%b exp=1", req_ready_a);
    end
    @(posedge clk); #1;
    req_valid_a = 1'b0;
  endtask

  task automatic issue_b(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_funct3 = f3; req_addr = a; req_data = d; req_valid_b = 1'b1;
    n_checks++;
    if (req_ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready_b got=%b exp=1", req_ready_b);
    end
    @(posedge clk); #1;
    req_valid_b = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (done_a === 1'b1) break;
    end
    n_checks++;
    if (done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout_a done=%b exp=1 after %0d cycles", done_a, cyc);
    end
  endtask

  // Independent byte-by-byte reference of where each store byte lands.
  task automatic push_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int          nb;
    int          p;
    logic [7:0]  lanes [0:7];
    logic [7:0]  be8;
    logic [31:0] base;
    case (f3)
      3'b000:  nb = 1;
      3'b001:  nb = 2;
      3'b010:  nb = 4;
      default: nb = 0;
    endcase
    if (nb == 0) begin
      exp_fault_q.push_back(1'b1);
    end else begin
      be8 = '0;
      for (int i = 0; i < 8; i++) lanes[i] = '0;
      for (int k = 0; k < nb; k++) begin
        p = int'(a[1:0]) + k;
        be8[p] = 1'b1;
        lanes[p] = d[8*k +: 8];
      end
      base = {a[31:2], 2'b00};
      exp_q.push_back({base, be8[3:0], lanes[3], lanes[2], lanes[1], lanes[0]});
      if (be8[7:4] != 4'b0000)
        exp_q.push_back({base + 32'd4, be8[7:4], lanes[7], lanes[6], lanes[5], lanes[4]});
      exp_fault_q.push_back(1'b0);
    end
  endtask

  // tests
  task automatic test_reset();
    req_valid_a = 1'b0; req_valid_b = 1'b0; mem_ready = 1'b0;
    req_funct3 = '0; req_addr = '0; req_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #3;
    n_checks++;
    if ({req_ready_a, mem_we_a, done_a, fault_a} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl got ready/we/done/fault=%b exp=1000",
               {req_ready_a, mem_we_a, done_a, fault_a});
    end
    n_checks++;
    if ({mem_addr_a, mem_be_a, mem_wdata_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem got addr=%h be=%b wdata=%h exp 0", mem_addr_a, mem_be_a, mem_wdata_a);
    end
    n_checks++;
    if (state_a !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got=%0d exp=%0d", state_a, IDLE);
    end
    n_checks++;
    if ({req_ready_b, mem_we_b, done_b, fault_b} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl_b got=%b exp=1000", {req_ready_b, mem_we_b, done_b, fault_b});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sw_aligned();
    int cyc;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    exp_q.push_back({32'h0000_00a8, 4'b1111, 32'hdead_beef});
    exp_fault_q.push_back(1'b0);
    issue_a(F3_SW, 32'h0000_00a8, 32'hdead_beef);
    @(negedge clk);
    n_checks++;
    if (mem_we_a !== 1'b1 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_first_cycle got we=%b done=%b exp we=1 done=0", mem_we_a, done_a);
    end
    wait_done_a(cyc);
    n_checks++;
    if (cyc + 1 !== 2) begin
      n_fail++;
      $display("FAIL sw_latency got=%0d exp=2", cyc + 1);
    end
  endtask

  task automatic test_sb();
    int cyc;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    exp_q.push_back({32'h0000_00a8, 4'b1000, 32'hef00_0000});
    exp_fault_q.push_back(1'b0);
    issue_a(F3_SB, 32'h0000_00ab, 32'h1234_56ef);
    wait_done_a(cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL sb_latency got=%0d exp=2", cyc);
    end
  endtask

  task automatic test_misaligned();
    int cyc;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    exp_q.push_back({32'h0000_00ac, 4'b1100, 32'hbabe_0000});
    exp_q.push_back({32'h0000_00b0, 4'b0011, 32'h0000_cafe});
    exp_fault_q.push_back(1'b0);
    issue_a(F3_SW, 32'h0000_00ae, 32'hcafe_babe);
    wait_done_a(cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL split_latency got=%0d exp=3", cyc);
    end
    @(posedge clk); #1;
    exp_q.push_back({32'hffff_fffc, 4'b1110, 32'h2233_4400});
    exp_q.push_back({32'h0000_0000, 4'b0001, 32'h0000_0011});
    exp_fault_q.push_back(1'b0);
    issue_a(F3_SW, 32'hffff_fffd, 32'h1122_3344);
    wait_done_a(cyc);
  endtask

  task automatic test_stall();
    int cyc;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    exp_q.push_back({32'h0000_0040, 4'b1111, 32'h55aa_33cc});
    exp_fault_q.push_back(1'b0);
    issue_a(F3_SW, 32'h0000_0040, 32'h55aa_33cc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_we_a, done_a, mem_addr_a, mem_be_a, mem_wdata_a} !==
          {1'b1, 1'b0, 32'h0000_0040, 4'b1111, 32'h55aa_33cc}) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d got we=%b done=%b addr=%h be=%b wdata=%h exp we=1 done=0 addr=00000040 be=1111 wdata=55aa33cc",
                 i, mem_we_a, done_a, mem_addr_a, mem_be_a, mem_wdata_a);
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    wait_done_a(cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL stall_latency got=%0d exp=2 after release", cyc);
    end
  endtask

  task automatic test_bad_funct3();
    @(posedge clk); #1;
    mem_ready = 1'b1;
    exp_fault_q.push_back(1'b1);
    issue_a(3'b011, 32'h0000_00a8, 32'h1111_2222);
    @(negedge clk);
    n_checks++;
    if ({mem_we_a, done_a, fault_a} !== 3'b011) begin
      n_fail++;
      $display("FAIL bad_funct3 got we/done/fault=%b exp=011", {mem_we_a, done_a, fault_a});
    end
  endtask

  task automatic test_no_misaligned();
    @(posedge clk); #1;
    mem_ready = 1'b1;
    issue_b(F3_SH, 32'h0000_00ab, 32'h1234_abcd);
    @(negedge clk);
    n_checks++;
    if ({done_b, fault_b, mem_we_b} !== 3'b110) begin
      n_fail++;
      $display("FAIL strict_reject got done/fault/we=%b exp=110", {done_b, fault_b, mem_we_b});
    end
    @(posedge clk); #1;
    issue_b(F3_SH, 32'h0000_00a9, 32'h1234_abcd);
    @(negedge clk);
    n_checks++;
    if ({mem_we_b, mem_addr_b, mem_be_b, mem_wdata_b} !== {1'b1, 32'h0000_00a8, 4'b0110, 32'h00ab_cd00}) begin
      n_fail++;
      $display("FAIL strict_sh got we=%b addr=%h be=%b wdata=%h exp we=1 addr=000000a8 be=0110 wdata=00abcd00",
               mem_we_b, mem_addr_b, mem_be_b, mem_wdata_b);
    end
    @(negedge clk);
    n_checks++;
    if ({done_b, fault_b, mem_we_b} !== 3'b100) begin
      n_fail++;
      $display("FAIL strict_sh_done got done/fault/we=%b exp=100", {done_b, fault_b, mem_we_b});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [2:0]  f3;
    logic [31:0] a, d;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      f3 = 3'($urandom_range(0, 2));
      a  = $urandom;
      d  = $urandom;
      push_model(f3, a, d);
      issue_a(f3, a, d);
      wait_done_a(cyc);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, d;
    logic        got;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      f3 = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? (32'hffff_fffc | 32'($urandom_range(0, 3))) : $urandom;
      d  = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      push_model(f3, a, d);
      issue_a(f3, a, d);
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (done_a === 1'b1) got = 1'b1;
        else begin
          @(posedge clk); #1;
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL random_done_timeout iter %0d done=%b exp=1", i, done_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mem_ready = 1'b1;
    exp_q.push_back({32'h0000_00ac, 4'b1100, 32'hbabe_0000});
    issue_a(F3_SW, 32'h0000_00ae, 32'hcafe_babe);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_a !== WRITE_HI || mem_we_a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_setup got state=%0d we=%b exp state=%0d we=1", state_a, mem_we_a, WRITE_HI);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_we_a, done_a, req_ready_a} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_reset_async got we/done/ready=%b exp=001", {mem_we_a, done_a, req_ready_a});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (done_a !== 1'b0 || req_ready_a !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_reset_after cycle %0d got done=%b ready=%b exp done=0 ready=1", i, done_a, req_ready_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_aligned();
    test_sb();
    test_misaligned();
    test_stall();
    test_bad_funct3();
    test_no_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0 || exp_fault_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain beats_left=%0d dones_left=%0d exp 0 and 0", exp_q.size(), exp_fault_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
